// File: rtl/ifetch_buffer_pkg.sv
// Shared CPU definitions used by the fetch stage and its bench.
package cpu_defs;

   localparam int unsigned AW       = 32;
   localparam logic [31:0] RESET_PC = 32'h0000_3000;
   localparam logic [31:0] NOP      = 32'h0000_0000;

endpackage

// File: rtl/ifetch_buffer_sync_fifo.sv
// Generic synchronous FIFO with push/pop/clear and an occupancy count.
// Push into a full FIFO and pop from an empty one are ignored; clear wins
// over push and pop in the same cycle.
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    clear_i,
   input  logic                    push_i,
   input  logic [WIDTH-1:0]        wdata_i,
   input  logic                    pop_i,
   output logic [WIDTH-1:0]        rdata_o,
   output logic [$clog2(DEPTH):0]  count_o
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   assign do_push = push_i & (count_q != FULL);
   assign do_pop  = pop_i & (count_q != '0);

   // Next-state pointers and count; pointers wrap naturally since DEPTH is a power of 2.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clear_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   // Pointer and count registers.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments; blocking is reserved for always_comb.
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array write.
   always_ff @(posedge clk) begin
      // NOTE: storage is not reset; count_q alone says which entries are meaningful.
      if (do_push && !clear_i) mem_q[wr_ptr_q] <= wdata_i;
   end

   assign rdata_o = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/ifetch_buffer.sv
// Fetch stage: issues in-order requests to a variable-latency instruction
// memory, pairs each response with its PC and buffers {pc, instr, exc} for
// decode. A flush discards buffered entries and drops in-flight responses.
module ifetch_buffer
   import cpu_defs::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned AW    = cpu_defs::AW
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [AW-1:0] pc_in,
   input  logic          pc_valid,
   output logic          pc_ready,
   input  logic          flush,
   output logic          imem_req_valid,
   input  logic          imem_req_ready,
   output logic [AW-1:0] imem_req_addr,
   input  logic          imem_rsp_valid,
   input  logic [31:0]   imem_rsp_data,
   output logic          id_valid,
   input  logic          id_ready,
   output logic [31:0]   id_instr,
   output logic [AW-1:0] id_pc,
   output logic          id_exc
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;
   localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

   typedef struct packed {
      logic [AW-1:0] pc;
      logic          exc;
   } pend_t;

   typedef struct packed {
      logic [AW-1:0] pc;
      logic [31:0]   instr;
      logic          exc;
   } ibuf_t;

   pend_t         pend_wr, pend_rd;
   ibuf_t         ibuf_wr, ibuf_rd;
   logic [CW-1:0] inflight, count;
   logic [CW-1:0] drop_q, drop_d;
   logic [CW:0]   occupancy;
   logic          run_q;
   logic          credit_ok, rsp_ok, rsp_keep, id_pop;

   // Hold off requests until the first edge after reset release.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) run_q <= 1'b0;
      else        run_q <= 1'b1;
   end

   // Credit counts both in-flight requests and buffered entries, so every
   // response is guaranteed a buffer slot.
   assign occupancy      = {1'b0, inflight} + {1'b0, count};
   assign credit_ok      = occupancy < DEPTH_W;
   assign imem_req_valid = run_q & pc_valid & credit_ok & ~flush;
   assign pc_ready       = imem_req_valid & imem_req_ready;
   assign imem_req_addr  = {pc_in[AW-1:2], 2'b00};

   // A response with nothing outstanding is a protocol error and is ignored.
   assign rsp_ok   = imem_rsp_valid & (inflight != '0);
   assign rsp_keep = rsp_ok & (drop_q == '0) & ~flush;
   assign id_valid = (count != '0);
   assign id_pop   = id_valid & id_ready & ~flush;

   assign pend_wr.pc    = pc_in;
   assign pend_wr.exc   = |pc_in[1:0];
   assign ibuf_wr.pc    = pend_rd.pc;
   assign ibuf_wr.exc   = pend_rd.exc;
   assign ibuf_wr.instr = pend_rd.exc ? NOP : imem_rsp_data;

   // In-flight PC queue: never cleared on flush so PC pairing stays aligned
   // with the responses still to come back.
   sync_fifo #(.WIDTH($bits(pend_t)), .DEPTH(DEPTH)) u_pend_q (
      .clk     (clk),
      .rst_n   (reset),
      .clear_i (1'b0),
      .push_i  (pc_ready),
      .wdata_i (pend_wr),
      .pop_i   (rsp_ok),
      .rdata_o (pend_rd),
      .count_o (inflight)
   );

   // Instruction buffer towards decode.
   sync_fifo #(.WIDTH($bits(ibuf_t)), .DEPTH(DEPTH)) u_ibuf (
      .clk     (clk),
      .rst_n   (reset),
      .clear_i (flush),
      .push_i  (rsp_keep),
      .wdata_i (ibuf_wr),
      .pop_i   (id_pop),
      .rdata_o (ibuf_rd),
      .count_o (count)
   );

   // Drop counter: a flush marks every response still outstanding after this edge as stale.
   always_comb begin
      drop_d = drop_q;
      if (flush)                        drop_d = inflight - CW'(rsp_ok);
      else if (rsp_ok && drop_q != '0)  drop_d = drop_q - 1'b1;
   end

   // Drop counter register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) drop_q <= '0;
      else        drop_q <= drop_d;
   end

   // Head fields read as zero while the buffer is empty.
   assign id_pc    = id_valid ? ibuf_rd.pc    : '0;
   assign id_instr = id_valid ? ibuf_rd.instr : NOP;
   assign id_exc   = id_valid & ibuf_rd.exc;

endmodule

// File: tb/tb_ifetch_buffer.sv
// Directed bench for ifetch_buffer with a behavioural in-order memory of
// configurable latency. Inputs change 1 time unit after the rising edge and
// outputs are compared 2 units after it.
module tb_ifetch_buffer;
   import cpu_defs::*;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] pc_in;
   logic        pc_valid, pc_ready, flush;
   logic        imem_req_valid, imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data  = 32'h0;
   logic        id_valid, id_ready, id_exc;
   logic [31:0] id_instr, id_pc;

   int checks   = 0;
   int failures = 0;
   int lat      = 0;
   int ncnt     = 0;
   int issued;
   int n;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } mreq_t;
   mreq_t pend[$];

   ifetch_buffer #(.DEPTH(4), .AW(32)) dut (
      .clk            (clk),
      .reset          (reset),
      .pc_in          (pc_in),
      .pc_valid       (pc_valid),
      .pc_ready       (pc_ready),
      .flush          (flush),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .id_valid       (id_valid),
      .id_ready       (id_ready),
      .id_instr       (id_instr),
      .id_pc          (id_pc),
      .id_exc         (id_exc)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return 32'hE000_0000 | {a[31:2], 2'b00};
   endfunction

   // Memory model: a request accepted at edge k is answered at edge k+1+lat.
   always @(negedge clk) begin
      ncnt++;
      if (!reset) begin
         pend.delete();
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = 32'h0;
      end else begin
         if (imem_rsp_valid) void'(pend.pop_front());
         if (imem_req_valid && imem_req_ready)
            pend.push_back('{addr: imem_req_addr, due: ncnt + 1 + lat});
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = 32'h0;
         if (pend.size() > 0) begin
            if (pend[0].due <= ncnt) begin
               imem_rsp_valid = 1'b1;
               imem_rsp_data  = mem_word(pend[0].addr);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      reset = 1'b0; pc_valid = 1'b1; pc_in = RESET_PC;
      flush = 1'b0; imem_req_ready = 1'b1; id_ready = 1'b0;

      // Reset state, with pc_valid held high.
      tick();
      #1;
      check("rst_id_valid", id_valid, 0);
      check("rst_id_pc", id_pc, 0);
      check("rst_id_instr", id_instr, 0);
      check("rst_id_exc", id_exc, 0);
      check("rst_req_valid", imem_req_valid, 0);
      check("rst_pc_ready", pc_ready, 0);
      pc_valid = 1'b0;
      tick();
      reset = 1'b1;
      tick();

      // 1: zero-latency memory, decode always ready.
      lat = 0; id_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         pc_valid = (i < 3);
         pc_in    = RESET_PC + 32'(4 * i);
         #1;
         if (i < 3) begin
            check("t1_pc_ready", pc_ready, 1);
            check("t1_req_addr", imem_req_addr, RESET_PC + 32'(4 * i));
         end
         check("t1_id_valid", id_valid, (i >= 2 && i <= 4));
         if (i >= 2 && i <= 4) begin
            check("t1_id_pc", id_pc, RESET_PC + 32'(4 * (i - 2)));
            check("t1_id_instr", id_instr, mem_word(RESET_PC + 32'(4 * (i - 2))));
            check("t1_id_exc", id_exc, 0);
         end
         tick();
      end

      // 2: decode stalled -> credit stops issue at DEPTH, then drain intact.
      id_ready = 1'b0; issued = 0;
      for (int i = 0; i < 8; i++) begin
         pc_valid = 1'b1;
         pc_in    = 32'h3100 + 32'(4 * issued);
         #1;
         check("t2_pc_ready", pc_ready, (i < 4));
         if (pc_ready) issued++;
         tick();
      end
      check("t2_issued", issued, 4);
      pc_valid = 1'b0; id_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         check("t2_drain_valid", id_valid, 1);
         check("t2_drain_pc", id_pc, 32'h3100 + 32'(4 * i));
         check("t2_drain_instr", id_instr, mem_word(32'h3100 + 32'(4 * i)));
         tick();
      end
      #1;
      check("t2_empty", id_valid, 0);
      tick();

      // 3: latency 3, two in flight, flush, redirect to 0x3040.
      lat = 3; id_ready = 1'b1;
      pc_valid = 1'b1; pc_in = 32'h3200; #1;
      check("t3_issue0", pc_ready, 1);
      tick();
      pc_in = 32'h3204; #1;
      check("t3_issue1", pc_ready, 1);
      tick();
      pc_in = 32'h3040; flush = 1'b1; #1;
      check("t3_flush_req_valid", imem_req_valid, 0);
      check("t3_flush_pc_ready", pc_ready, 0);
      tick();
      flush = 1'b0; #1;
      check("t3_redirect_issue", pc_ready, 1);
      check("t3_redirect_addr", imem_req_addr, 32'h3040);
      tick();
      pc_valid = 1'b0; n = 0; #1;
      while (!id_valid && n < 20) begin
         tick(); #1; n++;
      end
      check("t3_wait_cycles", n, 4);
      check("t3_id_pc", id_pc, 32'h3040);
      check("t3_id_instr", id_instr, mem_word(32'h3040));
      tick();

      // 4: misaligned PC, with one cycle of memory backpressure first.
      lat = 0; id_ready = 1'b0; imem_req_ready = 1'b0;
      pc_valid = 1'b1; pc_in = 32'h3002; #1;
      check("t4_bp_req_valid", imem_req_valid, 1);
      check("t4_bp_pc_ready", pc_ready, 0);
      check("t4_req_addr", imem_req_addr, 32'h3000);
      tick();
      imem_req_ready = 1'b1; #1;
      check("t4_issue_mis", pc_ready, 1);
      tick();
      pc_in = 32'h3008; #1;
      check("t4_issue_ok", pc_ready, 1);
      tick();
      pc_valid = 1'b0; #1;
      check("t4_id_valid", id_valid, 1);
      check("t4_id_pc", id_pc, 32'h3002);
      check("t4_id_exc", id_exc, 1);
      check("t4_id_instr", id_instr, 32'h0);
      tick();
      id_ready = 1'b1; #1;
      check("t4_hold_pc", id_pc, 32'h3002);
      tick();
      #1;
      check("t4_next_pc", id_pc, 32'h3008);
      check("t4_next_exc", id_exc, 0);
      check("t4_next_instr", id_instr, 32'hE000_3008);
      tick();
      #1;
      check("t4_empty", id_valid, 0);
      tick();

      // 5: flush coincides with a response and a decode pop.
      lat = 1; id_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         pc_valid = 1'b1; pc_in = 32'h3300 + 32'(4 * i); #1;
         check("t5_issue", pc_ready, 1);
         tick();
      end
      pc_in = 32'h3080; flush = 1'b1; id_ready = 1'b1; #1;
      check("t5_head_valid", id_valid, 1);
      check("t5_head_pc", id_pc, 32'h3300);
      check("t5_flush_pc_ready", pc_ready, 0);
      tick();
      flush = 1'b0; #1;
      check("t5_after_flush_valid", id_valid, 0);
      check("t5_redirect_issue", pc_ready, 1);
      tick();
      pc_valid = 1'b0; n = 0; #1;
      while (!id_valid && n < 20) begin
         tick(); #1; n++;
      end
      check("t5_wait_cycles", n, 2);
      check("t5_id_pc", id_pc, 32'h3080);
      check("t5_id_instr", id_instr, mem_word(32'h3080));
      tick();

      // 6: asynchronous reset in the middle of a burst.
      lat = 0; id_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         pc_valid = 1'b1; pc_in = 32'h3400 + 32'(4 * i); #1;
         check("t6_issue", pc_ready, 1);
         tick();
      end
      #1;
      check("t6_pre_valid", id_valid, 1);
      #1;
      reset = 1'b0;
      #1;
      check("t6_rst_id_valid", id_valid, 0);
      check("t6_rst_pc_ready", pc_ready, 0);
      check("t6_rst_req_valid", imem_req_valid, 0);
      check("t6_rst_id_pc", id_pc, 0);
      check("t6_rst_id_instr", id_instr, 0);
      tick();
      #1;
      check("t6_hold_id_valid", id_valid, 0);
      check("t6_hold_pc_ready", pc_ready, 0);
      reset = 1'b1; pc_in = RESET_PC;
      tick();
      #1;
      check("t6_restart_issue", pc_ready, 1);
      check("t6_restart_addr", imem_req_addr, RESET_PC);
      tick();
      pc_valid = 1'b0; id_ready = 1'b1; #1;
      check("t6_restart_wait", id_valid, 0);
      tick();
      #1;
      check("t6_restart_valid", id_valid, 1);
      check("t6_restart_pc", id_pc, RESET_PC);
      check("t6_restart_instr", id_instr, mem_word(RESET_PC));
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
